// File: rtl/sm83_dma_pkg.sv
// sm83_dma_pkg: shared types, constants and helpers for the SM83 OAM DMA arbiter.
// Contents: DMA state encoding, default register address and transfer
// parameters, IO/echo boundaries and the echo-RAM source mirroring helper.
package sm83_dma_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned CNT_W  = 8;

    localparam int unsigned DMA_LEN_DEF     = 160;
    localparam int unsigned START_DELAY_DEF = 1;

    localparam logic [ADDR_W-1:0] DMA_REG_ADDR_DEF = 16'hFF46;
    localparam logic [ADDR_W-1:0] IO_BASE          = 16'hFF00;
    localparam logic [DATA_W-1:0] ECHO_BASE_HI     = 8'hE0;
    localparam logic [DATA_W-1:0] ECHO_OFFSET      = 8'h20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        ACTIVE = 2'd2
    } dma_state_t;

    // Sources in the echo region fold back onto work RAM.
    function automatic logic [DATA_W-1:0] mirror_hi(input logic [DATA_W-1:0] hi);
        return (hi >= ECHO_BASE_HI) ? DATA_W'(hi - ECHO_OFFSET) : hi;
    endfunction

endpackage

// File: rtl/sm83_dma_engine.sv
// sm83_dma_engine: OAM DMA state machine, byte index, source page and OAM strobe.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   t3, t4              phase strobes (data latch / M-cycle boundary)
//   reg_wr, reg_wdata   CPU write to the DMA register, valid on t4
//   bus_din             external bus read data
//   dma_addr            source address for the current DMA M-cycle
//   dma_active          DMA owns the bus this M-cycle (registered)
//   oam_addr/din/wr     OAM write port (registered, strobe high in the t4 cycle)
//   src_hi              raw source page (only with SM83_DMA_READBACK_EN)
module sm83_dma_engine
    import sm83_dma_pkg::*;
#(
    parameter int unsigned DMA_LEN     = DMA_LEN_DEF,
    parameter int unsigned START_DELAY = START_DELAY_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              t3,
    input  logic              t4,
    input  logic              reg_wr,
    input  logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] bus_din,
    output logic [ADDR_W-1:0] dma_addr,
    output logic              dma_active,
    output logic [IDX_W-1:0]  oam_addr,
    output logic [DATA_W-1:0] oam_din,
    output logic              oam_wr
`ifdef SM83_DMA_READBACK_EN
    ,
    output logic [DATA_W-1:0] src_hi
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DMA_LEN - 1);
    localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(START_DELAY);

    dma_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] src_hi_q, src_hi_d;
    logic [DATA_W-1:0] eff_hi_q, eff_hi_d;
    logic              active_q, active_d;
    logic [IDX_W-1:0]  oam_addr_q, oam_addr_d;
    logic [DATA_W-1:0] oam_din_q, oam_din_d;
    logic              oam_wr_q, oam_wr_d;
    logic              launch;

    // Next-state logic. A pending start delay runs alongside an ongoing
    // transfer so a restart does not stall the old copy.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        src_hi_d   = src_hi_q;
        eff_hi_d   = eff_hi_q;
        active_d   = active_q;
        oam_addr_d = oam_addr_q;
        oam_din_d  = oam_din_q;
        oam_wr_d   = 1'b0;
        launch     = 1'b0;

        // Byte read at t3 becomes the OAM write presented during t4.
        if (t3 && (state_q == ACTIVE)) begin
            oam_wr_d   = 1'b1;
            oam_addr_d = idx_q;
            oam_din_d  = bus_din;
        end

        if (t4) begin
            if (reg_wr) begin
                src_hi_d = reg_wdata;
                if (START_DELAY == 0) begin
                    launch = 1'b1;
                end else begin
                    pend_d = 1'b1;
                    cnt_d  = DELAY_LD;
                end
            end else if (pend_q) begin
                if (cnt_q <= CNT_W'(1)) begin
                    launch = 1'b1;
                end else begin
                    cnt_d = CNT_W'(cnt_q - CNT_W'(1));
                end
            end

            if (launch) begin
                state_d  = ACTIVE;
                idx_d    = '0;
                eff_hi_d = mirror_hi(src_hi_d);
                pend_d   = 1'b0;
            end else if ((state_q == ACTIVE) && (idx_q != LAST_IDX)) begin
                idx_d = IDX_W'(idx_q + IDX_W'(1));
            end else if (pend_d) begin
                state_d = START;
            end else begin
                state_d = IDLE;
            end

            active_d = (state_d == ACTIVE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            src_hi_q   <= '0;
            eff_hi_q   <= '0;
            active_q   <= 1'b0;
            oam_addr_q <= '0;
            oam_din_q  <= '0;
            oam_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            src_hi_q   <= src_hi_d;
            eff_hi_q   <= eff_hi_d;
            active_q   <= active_d;
            oam_addr_q <= oam_addr_d;
            oam_din_q  <= oam_din_d;
            oam_wr_q   <= oam_wr_d;
        end
    end

    assign dma_addr   = {eff_hi_q, idx_q};
    assign dma_active = active_q;
    assign oam_addr   = oam_addr_q;
    assign oam_din    = oam_din_q;
    assign oam_wr     = oam_wr_q;
`ifdef SM83_DMA_READBACK_EN
    assign src_hi     = src_hi_q;
`endif

endmodule

// File: rtl/sm83_dma_arbiter.sv
// sm83_dma_arbiter: owns the CPU external bus and shares it with the OAM DMA
// engine on M-cycle boundaries; blocks CPU accesses below 0xFF00 while DMA runs.
// Optional: define SM83_DMA_READBACK_EN to make the DMA register readable.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   t1..t4                       one-hot phase strobes from the sequencer
//   cpu_addr/rd/wr/dout, cpu_din CPU side of the bus (cpu_din registered at t3)
//   bus_addr/rd/wr/dout, bus_din external bus (follows phase strobes)
//   oam_addr/din/wr              OAM write port driven by the DMA engine
//   dma_active                   DMA owns the external bus
module sm83_dma_arbiter
    import sm83_dma_pkg::*;
#(
    parameter int unsigned       DMA_LEN      = DMA_LEN_DEF,
    parameter logic [ADDR_W-1:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
    parameter int unsigned       START_DELAY  = START_DELAY_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              t1,
    input  logic              t2,
    input  logic              t3,
    input  logic              t4,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_dout,
    output logic [DATA_W-1:0] cpu_din,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [DATA_W-1:0] bus_dout,
    input  logic [DATA_W-1:0] bus_din,
    output logic [IDX_W-1:0]  oam_addr,
    output logic [DATA_W-1:0] oam_din,
    output logic              oam_wr,
    output logic              dma_active
);

    logic              in_io;
    logic              reg_hit;
    logic              reg_wr;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] rb_data;
    logic [DATA_W-1:0] cpu_din_q, cpu_din_d;
`ifdef SM83_DMA_READBACK_EN
    logic [DATA_W-1:0] src_hi;
`endif

    assign in_io   = (cpu_addr >= IO_BASE);
    assign reg_hit = (cpu_addr == DMA_REG_ADDR);
    assign reg_wr  = t4 && cpu_wr && reg_hit;

    sm83_dma_engine #(
        .DMA_LEN     (DMA_LEN),
        .START_DELAY (START_DELAY)
    ) u_engine (
        .clk        (clk),
        .reset_n    (reset_n),
        .t3         (t3),
        .t4         (t4),
        .reg_wr     (reg_wr),
        .reg_wdata  (cpu_dout),
        .bus_din    (bus_din),
        .dma_addr   (dma_addr),
        .dma_active (dma_active),
        .oam_addr   (oam_addr),
        .oam_din    (oam_din),
        .oam_wr     (oam_wr)
`ifdef SM83_DMA_READBACK_EN
        ,
        .src_hi     (src_hi)
`endif
    );

`ifdef SM83_DMA_READBACK_EN
    assign rb_data = src_hi;
`else
    assign rb_data = 8'hFF;
`endif

    // Bus strobes track the phase strobes directly so they line up with t1..t3.
    // Ownership only changes on t4, so it is stable across the whole M-cycle.
    always_comb begin
        bus_addr = '0;
        bus_rd   = 1'b0;
        bus_wr   = 1'b0;
        bus_dout = '0;
        if (reset_n) begin
            if (dma_active) begin
                bus_addr = dma_addr;
                bus_rd   = t1 || t2 || t3;
            end else begin
                bus_addr = cpu_addr;
                bus_dout = cpu_dout;
                if (!in_io) begin
                    bus_rd = cpu_rd && (t1 || t2 || t3);
                    bus_wr = cpu_wr && t3;
                end
            end
        end
    end

    // CPU read data: register readback, blocked read, or bus data.
    always_comb begin
        cpu_din_d = cpu_din_q;
        if (t3 && cpu_rd) begin
            if (reg_hit) begin
                cpu_din_d = rb_data;
            end else if (dma_active && !in_io) begin
                cpu_din_d = 8'hFF;
            end else begin
                cpu_din_d = bus_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cpu_din_q <= 8'hFF;
        end else begin
            cpu_din_q <= cpu_din_d;
        end
    end

    assign cpu_din = cpu_din_q;

endmodule

// File: tb/tb_sm83_dma_arbiter.sv
// tb_sm83_dma_arbiter: directed + randomized bench for sm83_dma_arbiter.
// The reference keeps a list of scheduled transfers (start M-cycle, source page);
// the owner of any M-cycle is the most recently started transfer still in range.
module tb_sm83_dma_arbiter;

    localparam int LEN = 160;
    localparam int DLY = 1;
`ifdef SM83_DMA_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        t1, t2, t3, t4;
    logic [15:0] cpu_addr;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  cpu_dout, cpu_din;
    logic [15:0] bus_addr;
    logic        bus_rd, bus_wr;
    logic [7:0]  bus_dout, bus_din;
    logic [7:0]  oam_addr, oam_din;
    logic        oam_wr, dma_active;

    always #5 clk = ~clk;

    sm83_dma_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .t1         (t1),
        .t2         (t2),
        .t3         (t3),
        .t4         (t4),
        .cpu_addr   (cpu_addr),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_dout   (cpu_dout),
        .cpu_din    (cpu_din),
        .bus_addr   (bus_addr),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .bus_dout   (bus_dout),
        .bus_din    (bus_din),
        .oam_addr   (oam_addr),
        .oam_din    (oam_din),
        .oam_wr     (oam_wr),
        .dma_active (dma_active)
    );

    typedef struct {
        int         start;
        logic [7:0] base;
    } xfer_t;

    xfer_t       xq[$];
    int          mk = 0;
    int          checks = 0;
    int          passed = 0;
    logic [7:0]  src_m = 8'h00;
    logic [7:0]  cpu_din_m = 8'hFF;
    logic [7:0]  last_bd;
    logic [15:0] p1_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h (m-cycle %0d)", tag, obs, exp, mk);
    endtask

    // Which transfer (if any) owns M-cycle k, and at which byte.
    function automatic void lookup(input int k, output logic act,
                                   output logic [7:0] base, output logic [7:0] idx);
        int best;
        best = -1;
        act  = 1'b0;
        base = 8'h00;
        idx  = 8'h00;
        foreach (xq[i]) begin
            if (xq[i].start <= k && (best < 0 || xq[i].start > xq[best].start)) best = i;
        end
        if (best >= 0 && (k - xq[best].start) < LEN) begin
            act  = 1'b1;
            base = xq[best].base;
            idx  = 8'(k - xq[best].start);
        end
    endfunction

    function automatic int model_idx();
        logic act;
        logic [7:0] b, i;
        lookup(mk, act, b, i);
        return act ? int'(i) : -1;
    endfunction

    // One M-cycle of CPU activity, checked phase by phase.
    task automatic mcyc(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] wd);
        logic act, io;
        logic [7:0] base, idx, bd;
        logic [15:0] exp_addr;
        lookup(mk, act, base, idx);
        io       = (a >= 16'hFF00);
        bd       = 8'($urandom);
        last_bd  = bd;
        cpu_addr = a;
        cpu_rd   = rd;
        cpu_wr   = wr;
        cpu_dout = wd;
        bus_din  = bd;
        exp_addr = act ? {base, idx} : a;
        for (int p = 1; p <= 4; p++) begin
            t1 = (p == 1);
            t2 = (p == 2);
            t3 = (p == 3);
            t4 = (p == 4);
            @(negedge clk);
            if (p == 1) p1_addr = bus_addr;
            check("bus_addr", bus_addr, exp_addr);
            check("bus_rd", bus_rd, act ? (p <= 3) : (rd && !io && p <= 3));
            check("bus_wr", bus_wr, !act && wr && !io && p == 3);
            check("dma_active", dma_active, act);
            check("oam_wr", oam_wr, act && p == 4);
            check("cpu_din", cpu_din, cpu_din_m);
            if (act && p == 4) begin
                check("oam_addr", oam_addr, idx);
                check("oam_din", oam_din, bd);
            end
            if (!act && wr && !io && p == 3) check("bus_dout", bus_dout, wd);
            if (p == 3 && rd) begin
                if (a == 16'hFF46) cpu_din_m = RB_EN ? src_m : 8'hFF;
                else if (act && !io) cpu_din_m = 8'hFF;
                else cpu_din_m = bd;
            end
            @(posedge clk);
            #1;
        end
        t4 = 1'b0;
        if (wr && a == 16'hFF46) begin
            src_m = wd;
            for (int i = xq.size() - 1; i >= 0; i--) begin
                if (xq[i].start > mk) xq.delete(i);
            end
            xq.push_back('{mk + 1 + DLY, (wd >= 8'hE0) ? 8'(wd - 8'h20) : wd});
        end
        mk++;
    endtask

    // Random CPU access; DMA register writes are kept for the directed steps.
    task automatic rand_op();
        int sel, kind;
        logic [15:0] a;
        sel  = $urandom_range(0, 9);
        kind = $urandom_range(0, 2);
        if (sel <= 5) a = 16'($urandom_range(0, 16'hFEFF));
        else if (sel <= 8) a = 16'($urandom_range(16'hFF00, 16'hFFFE));
        else a = 16'hFF46;
        if (a == 16'hFF46 && kind == 2) kind = 1;
        mcyc(a, kind == 1, kind == 2, 8'($urandom));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        {t1, t2, t3, t4} = 4'b0000;
        cpu_addr = 16'h1234;
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h55;
        bus_din  = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dma_active", dma_active, 1'b0);
        check("rst_oam_wr", oam_wr, 1'b0);
        check("rst_cpu_din", cpu_din, 8'hFF);
        check("rst_bus_addr", bus_addr, 16'h0000);
        check("rst_bus_rd", bus_rd, 1'b0);
        check("rst_bus_wr", bus_wr, 1'b0);
        check("rst_oam_addr", oam_addr, 8'h00);
        check("rst_oam_din", oam_din, 8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Register readback, then let that transfer run out.
        mcyc(16'hFF46, 1'b0, 1'b1, 8'h9A);
        mcyc(16'hFF46, 1'b1, 1'b0, 8'h00);
        check("readback", cpu_din, RB_EN ? 8'h9A : 8'hFF);
        for (int i = 0; i < 165; i++) rand_op();

        // Full transfer from 0xC100 with directed blocking accesses mixed in.
        mcyc(16'hFF46, 1'b0, 1'b1, 8'hC1);
        for (int i = 0; i <= 160; i++) begin
            if (i == 1) begin
                mcyc(16'h0000, 1'b0, 1'b0, 8'h00);
                check("first_dma_addr", p1_addr, 16'hC100);
            end else if (i == 20) begin
                mcyc(16'h8000, 1'b1, 1'b0, 8'h00);
                check("blocked_rd", cpu_din, 8'hFF);
            end else if (i == 21) begin
                mcyc(16'hFF85, 1'b1, 1'b0, 8'h00);
                check("hram_rd", cpu_din, last_bd);
            end else if (i == 22) begin
                mcyc(16'hC000, 1'b0, 1'b1, 8'h77);
            end else begin
                rand_op();
            end
        end
        check("dma_end", dma_active, 1'b0);

        // Echo mirroring, then restart at idx 50.
        mcyc(16'hFF46, 1'b0, 1'b1, 8'hE3);
        rand_op();
        rand_op();
        check("echo_addr", p1_addr, 16'hC300);
        for (int i = 0; i < 300 && model_idx() != 50; i++) rand_op();
        check("reach_idx50", dma_active, 1'b1);
        mcyc(16'hFF46, 1'b0, 1'b1, 8'hD0);
        rand_op();
        check("restart_old", p1_addr, 16'hC333);
        rand_op();
        check("restart_new", p1_addr, 16'hD000);

        // Register write in the last ACTIVE M-cycle.
        for (int i = 0; i < 300 && model_idx() != 159; i++) rand_op();
        mcyc(16'hFF46, 1'b0, 1'b1, 8'h80);
        rand_op();
        check("last_start_gap", p1_addr != 16'h8000, 1'b1);
        rand_op();
        check("last_restart_addr", p1_addr, 16'h8000);

        // Reset in the middle of the transfer.
        for (int i = 0; i < 300 && model_idx() != 40; i++) rand_op();
        check("reach_idx40", dma_active, 1'b1);
        t1 = 1'b1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        t1 = 1'b0;
        @(negedge clk);
        check("midrst_dma_active", dma_active, 1'b0);
        check("midrst_oam_wr", oam_wr, 1'b0);
        check("midrst_cpu_din", cpu_din, 8'hFF);
        check("midrst_bus_rd", bus_rd, 1'b0);
        xq.delete();
        src_m = 8'h00;
        cpu_din_m = 8'hFF;
        mk = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) rand_op();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
